jtbubl_snd_comm: RTL and testbench
==================================

// Module: jtbubl_snd_comm
// PURPOSE
//  Mailbox between main CPU (jtbubl_main) and sound CPU (jtbubl_sound), clocked on clk24.
//  Main->sound command latch with pending flag and gated sound NMI; sound->main reply latch with flag.
//  Overrun detection on both paths. Produces snd_latch and snd_nmi_n for the sound stage.
// PARAMETERS
//  DEPTH        4   m2s FIFO depth, power of 2, >=2; used only with JTBUBL_SNDCOMM_FIFO_EN
//  NMI_EN_RST   0   value of NMI-enable flag after reset
// PORTS
//  clk24        in   1  24 MHz system clock, single clock domain
//  rst_n        in   1  synchronous reset, active low
//  main_wr      in   1  1-cycle strobe: main writes command (main_dout)
//  main_rd      in   1  1-cycle strobe: main reads reply
//  main_dout    in   8  command byte from main CPU
//  main_din     out  8  reply byte to main CPU (s2m latch)
//  main_stat    out  4  {m2s_ovr, s2m_ovr, m2s_full, s2m_full}
//  snd_rd       in   1  1-cycle strobe: sound reads command
//  snd_wr       in   1  1-cycle strobe: sound writes reply (snd_dout)
//  snd_dout     in   8  reply byte from sound CPU
//  snd_latch    out  8  command byte to sound CPU (head of m2s path)
//  snd_nmi_on   in   1  1-cycle strobe: enable NMI
//  snd_nmi_off  in   1  1-cycle strobe: disable NMI
//  snd_nmi_n    out  1  NMI to sound CPU, active low
//  snd_stat     out  2  {m2s_full, s2m_full} as seen by sound CPU
// BEHAVIOUR
//  Reset (rst_n=0 on rising clk24): snd_latch=0, main_din=0, flags=0, ovr=0, nmi_en=NMI_EN_RST,
//   snd_nmi_n=1, main_stat=0, snd_stat=0. Reset mid-transfer discards pending data.
//  All outputs registered; flags/latches visible 1 cycle after the strobe.
//  m2s path: main_wr -> latch<=main_dout, m2s_full<=1. main_wr while full -> overwrite, m2s_ovr<=1.
//   snd_rd -> m2s_full<=0. snd_rd while empty -> no effect.
//   main_wr and snd_rd same cycle -> write wins: new data, m2s_full stays 1, no overrun.
//  s2m path symmetric: snd_wr sets s2m_full (overrun if full), main_rd clears it; same-cycle write wins.
//  Overrun bits sticky; cleared only by a main_rd of reply when s2m_full=0 (ack read) or reset.
//  NMI: snd_nmi_n = ~(m2s_full & nmi_en), registered. snd_nmi_on/off set/clear nmi_en;
//   both in same cycle -> off wins. Command arriving while disabled holds NMI pending;
//   enabling later asserts NMI next cycle. NMI deasserts 1 cycle after snd_rd empties path.
//  Strobes wider than 1 cycle act as repeated strobes; callers must edge-gate.
// CONFIGURATION
//  JTBUBL_SNDCOMM_FIFO_EN defined: m2s path is a DEPTH-entry FIFO. snd_latch = head entry;
//   snd_rd pops; m2s_full means not-empty; write when count==DEPTH is dropped and sets m2s_ovr;
//   simultaneous push+pop with count==DEPTH accepted (count unchanged). Pointers wrap mod DEPTH.
//   NMI stays asserted while FIFO not empty and nmi_en=1.
//  Not defined: single 8-bit latch as above; DEPTH ignored.
// STRUCTURE
//  Shared package constants (jtbubl_pkg): STAT_* bit positions for main_stat/snd_stat.
//  One sub-module: jtbubl_comm_fifo (sync FIFO, count, wrap pointers), instantiated only under the macro.
//  s2m path and NMI logic inline.
// TESTING
//  Reset: hold rst_n=0 2 cycles after traffic -> all outputs zero, snd_nmi_n=1, nmi_en=NMI_EN_RST.
//  nmi_on; main_wr 8'h5A -> next cycle snd_latch=5A, main_stat[1]=1, snd_nmi_n=0; snd_rd -> snd_nmi_n=1.
//  nmi_off; main_wr 8'h11 -> snd_nmi_n stays 1; nmi_on 10 cycles later -> snd_nmi_n=0 next cycle.
//  main_wr 8'h01 then 8'h02 without snd_rd -> snd_latch=02, m2s_ovr=1 (latch mode).
//  main_wr 8'h33 and snd_rd same cycle -> snd_latch=33, m2s_full=1, ovr=0.
//  snd_wr 8'hC3; main_rd -> main_din=C3, s2m_full 1->0.
//  FIFO_EN, DEPTH=4: 5 writes 01..05 -> 05 dropped, m2s_ovr=1; 4 pops return 01,02,03,04 then NMI releases.

Source files
------------

// File: rtl/jtbubl_snd_comm_pkg.sv
// Shared constants for the main/sound CPU mailbox.
//  STAT_*     : bit positions inside main_stat
//  SND_STAT_* : bit positions inside snd_stat
package jtbubl_snd_comm_pkg;

    localparam int STAT_S2M_FULL     = 0;
    localparam int STAT_M2S_FULL     = 1;
    localparam int STAT_S2M_OVR      = 2;
    localparam int STAT_M2S_OVR      = 3;

    localparam int SND_STAT_S2M_FULL = 0;
    localparam int SND_STAT_M2S_FULL = 1;

    // Overrun flag next state: a new overrun always lands, otherwise the
    // flag survives until an acknowledge read.
    function automatic logic ovr_next(input logic cur, input logic set, input logic ack);
        return set | (cur & ~ack);
    endfunction

endpackage

// File: rtl/jtbubl_snd_comm_if.sv
// Mailbox bus between the CPUs (master side) and jtbubl_snd_comm (slave side).
//  main_wr/main_rd/main_dout, main_din/main_stat   : main CPU side
//  snd_rd/snd_wr/snd_dout, snd_latch/snd_stat      : sound CPU side
//  snd_nmi_on/snd_nmi_off, snd_nmi_n               : sound NMI control
interface jtbubl_snd_comm_if;

    logic       main_wr;
    logic       main_rd;
    logic [7:0] main_dout;
    logic [7:0] main_din;
    logic [3:0] main_stat;
    logic       snd_rd;
    logic       snd_wr;
    logic [7:0] snd_dout;
    logic [7:0] snd_latch;
    logic       snd_nmi_on;
    logic       snd_nmi_off;
    logic       snd_nmi_n;
    logic [1:0] snd_stat;

    modport master (
        output main_wr, main_rd, main_dout, snd_rd, snd_wr, snd_dout,
               snd_nmi_on, snd_nmi_off,
        input  main_din, main_stat, snd_latch, snd_nmi_n, snd_stat
    );

    modport slave (
        input  main_wr, main_rd, main_dout, snd_rd, snd_wr, snd_dout,
               snd_nmi_on, snd_nmi_off,
        output main_din, main_stat, snd_latch, snd_nmi_n, snd_stat
    );

endinterface

// File: rtl/jtbubl_comm_fifo.sv
// Synchronous command FIFO for the main->sound path.
//  clk, rst_n    : clock, synchronous active-low reset
//  push, din     : write strobe and byte (dropped when full unless popping too)
//  pop           : read strobe (ignored when empty)
//  head          : registered head entry (holds last value once drained)
//  not_empty     : registered, count != 0
//  not_empty_nxt : value not_empty takes at the next edge
//  drop          : current push is being discarded
module jtbubl_comm_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       not_empty,
    output logic       not_empty_nxt,
    output logic       drop
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]    CNT_ZERO = (AW+1)'(0);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_next_s;
    logic [AW:0]   count_r, count_nxt_s;
    logic [7:0]    head_r, head_nxt_s;
    logic          not_empty_r;
    logic          do_push_s, do_pop_s;

    // Accept/pop decisions, next count and next registered head entry
    always_comb begin
        do_pop_s    = pop & (count_r != CNT_ZERO);
        // a pop in the same cycle frees the slot the push needs
        do_push_s   = push & ((count_r != CNT_FULL) | do_pop_s);
        drop        = push & ~do_push_s;
        rd_next_s   = rd_ptr_r + AW'(1);
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        // the incoming byte becomes head only when nothing older remains
        if (do_push_s && ((count_r == CNT_ZERO) || (do_pop_s && count_r == CNT_ONE))) begin
            head_nxt_s = din;
        end else if (do_pop_s && count_r != CNT_ONE) begin
            head_nxt_s = mem_r[rd_next_s];
        end else begin
            head_nxt_s = head_r;
        end
        not_empty_nxt = (count_nxt_s != CNT_ZERO);
    end

    // Storage, wrapping pointers, count and registered head
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
            rd_ptr_r    <= AW'(0);
            wr_ptr_r    <= AW'(0);
            count_r     <= CNT_ZERO;
            head_r      <= 8'h00;
            not_empty_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) rd_ptr_r <= rd_next_s;
            count_r     <= count_nxt_s;
            head_r      <= head_nxt_s;
            not_empty_r <= not_empty_nxt;
        end
    end

    assign head      = head_r;
    assign not_empty = not_empty_r;

endmodule

// File: rtl/jtbubl_snd_comm.sv
// Mailbox between the main CPU and the sound CPU, clocked on clk24.
//  main->sound: command latch (or FIFO) with pending flag gating the sound NMI
//  sound->main: reply latch with pending flag
//  Sticky overrun flags on both paths, cleared by a main reply read while
//  no reply is pending (acknowledge read).
// Ports: clk24, rst_n (synchronous, active low), bus (jtbubl_snd_comm_if.slave).
// Parameters: DEPTH (FIFO depth), NMI_EN_RST (NMI enable after reset).
// Build option: JTBUBL_SNDCOMM_FIFO_EN turns the command latch into a
// DEPTH-entry FIFO (jtbubl_comm_fifo); DEPTH is unused otherwise.
module jtbubl_snd_comm
    import jtbubl_snd_comm_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter bit NMI_EN_RST = 1'b0
) (
    input  logic               clk24,
    input  logic               rst_n,
    jtbubl_snd_comm_if.slave   bus
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("jtbubl_snd_comm: DEPTH must be a power of two >= 2");
    end

    logic [7:0] head_s;
    logic       m2s_full_s, m2s_full_nxt_s, m2s_drop_s;

`ifdef JTBUBL_SNDCOMM_FIFO_EN
    jtbubl_comm_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk           (clk24),
        .rst_n         (rst_n),
        .push          (bus.main_wr),
        .pop           (bus.snd_rd),
        .din           (bus.main_dout),
        .head          (head_s),
        .not_empty     (m2s_full_s),
        .not_empty_nxt (m2s_full_nxt_s),
        .drop          (m2s_drop_s)
    );
`else
    logic [7:0] cmd_r;
    logic       m2s_full_r;

    // Single latch: a write always wins over a same-cycle read
    always_comb begin
        if (bus.main_wr) begin
            m2s_full_nxt_s = 1'b1;
        end else if (bus.snd_rd) begin
            m2s_full_nxt_s = 1'b0;
        end else begin
            m2s_full_nxt_s = m2s_full_r;
        end
        // overwrite of an unread command; a same-cycle read consumed it
        m2s_drop_s = bus.main_wr & m2s_full_r & ~bus.snd_rd;
    end

    // Command latch and its pending flag
    always_ff @(posedge clk24) begin
        if (!rst_n) begin
            cmd_r      <= 8'h00;
            m2s_full_r <= 1'b0;
        end else begin
            if (bus.main_wr) cmd_r <= bus.main_dout;
            m2s_full_r <= m2s_full_nxt_s;
        end
    end

    assign head_s     = cmd_r;
    assign m2s_full_s = m2s_full_r;
`endif

    logic [7:0] reply_r;
    logic       s2m_full_r, m2s_ovr_r, s2m_ovr_r, nmi_en_r, snd_nmi_n_r;
    logic       nmi_en_nxt_s, ack_s, s2m_drop_s;

    // NMI enable next state (off wins) and overrun set/clear terms
    always_comb begin
        if (bus.snd_nmi_off) begin
            nmi_en_nxt_s = 1'b0;
        end else if (bus.snd_nmi_on) begin
            nmi_en_nxt_s = 1'b1;
        end else begin
            nmi_en_nxt_s = nmi_en_r;
        end
        ack_s      = bus.main_rd & ~s2m_full_r;
        s2m_drop_s = bus.snd_wr & s2m_full_r & ~bus.main_rd;
    end

    // Reply latch, flags, overruns and NMI output
    always_ff @(posedge clk24) begin
        if (!rst_n) begin
            reply_r     <= 8'h00;
            s2m_full_r  <= 1'b0;
            m2s_ovr_r   <= 1'b0;
            s2m_ovr_r   <= 1'b0;
            nmi_en_r    <= NMI_EN_RST;
            snd_nmi_n_r <= 1'b1;
        end else begin
            if (bus.snd_wr) begin
                reply_r    <= bus.snd_dout;
                s2m_full_r <= 1'b1;
            end else if (bus.main_rd) begin
                s2m_full_r <= 1'b0;
            end
            m2s_ovr_r   <= ovr_next(m2s_ovr_r, m2s_drop_s, ack_s);
            s2m_ovr_r   <= ovr_next(s2m_ovr_r, s2m_drop_s, ack_s);
            nmi_en_r    <= nmi_en_nxt_s;
            // built from next-state values so NMI tracks the flags with no extra lag
            snd_nmi_n_r <= ~(m2s_full_nxt_s & nmi_en_nxt_s);
        end
    end

    assign bus.snd_latch                      = head_s;
    assign bus.main_din                       = reply_r;
    assign bus.snd_nmi_n                      = snd_nmi_n_r;
    assign bus.main_stat[STAT_M2S_OVR]        = m2s_ovr_r;
    assign bus.main_stat[STAT_S2M_OVR]        = s2m_ovr_r;
    assign bus.main_stat[STAT_M2S_FULL]       = m2s_full_s;
    assign bus.main_stat[STAT_S2M_FULL]       = s2m_full_r;
    assign bus.snd_stat[SND_STAT_M2S_FULL]    = m2s_full_s;
    assign bus.snd_stat[SND_STAT_S2M_FULL]    = s2m_full_r;

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// Self-checking bench for jtbubl_snd_comm (latch build, or FIFO build when
// JTBUBL_SNDCOMM_FIFO_EN is defined). The reference model keeps the command
// path as a byte queue with a capacity and the reply path as a value + flag.
`timescale 1ns/1ps
module tb_jtbubl_snd_comm;

    localparam int DEPTH      = 4;
    localparam bit NMI_EN_RST = 1'b0;
`ifdef JTBUBL_SNDCOMM_FIFO_EN
    localparam int M2S_CAP    = DEPTH;
    localparam bit FIFO_MODE  = 1'b1;
`else
    localparam int M2S_CAP    = 1;
    localparam bit FIFO_MODE  = 1'b0;
`endif

    logic clk24 = 1'b0;
    logic rst_n = 1'b0;

    jtbubl_snd_comm_if bus();

    jtbubl_snd_comm #(.DEPTH(DEPTH), .NMI_EN_RST(NMI_EN_RST)) dut (
        .clk24 (clk24),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk24 = ~clk24;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m2s_q[$];
    logic [7:0] exp_latch, exp_reply;
    bit         exp_s_full, exp_m_ovr, exp_s_ovr, exp_nmi_en;

    function automatic logic [3:0] exp_main_stat();
        return {exp_m_ovr, exp_s_ovr, (m2s_q.size() != 0), exp_s_full};
    endfunction

    function automatic logic exp_nmi_n();
        return !((m2s_q.size() != 0) && exp_nmi_en);
    endfunction

    task automatic model_reset();
        m2s_q.delete();
        exp_latch  = 8'h00;
        exp_reply  = 8'h00;
        exp_s_full = 1'b0;
        exp_m_ovr  = 1'b0;
        exp_s_ovr  = 1'b0;
        exp_nmi_en = NMI_EN_RST;
    endtask

    // One clock with the given strobes; model advanced alongside
    task automatic cycle(input bit wr, input bit rd, input bit sw, input bit mr,
                         input bit on, input bit off,
                         input logic [7:0] md, input logic [7:0] sd);
        bit ack;
        bus.main_wr = wr;  bus.snd_rd = rd;  bus.snd_wr = sw;  bus.main_rd = mr;
        bus.snd_nmi_on = on;  bus.snd_nmi_off = off;
        bus.main_dout = md;  bus.snd_dout = sd;
        ack = mr && !exp_s_full;
        if (ack) begin
            exp_m_ovr = 1'b0;
            exp_s_ovr = 1'b0;
        end
        if (rd && m2s_q.size() > 0) void'(m2s_q.pop_front());
        if (wr) begin
            if (m2s_q.size() < M2S_CAP) begin
                m2s_q.push_back(md);
            end else begin
                exp_m_ovr = 1'b1;
                if (!FIFO_MODE) m2s_q[0] = md;
            end
        end
        if (m2s_q.size() > 0) exp_latch = m2s_q[0];
        if (sw) begin
            if (exp_s_full && !mr) exp_s_ovr = 1'b1;
            exp_reply  = sd;
            exp_s_full = 1'b1;
        end else if (mr) begin
            exp_s_full = 1'b0;
        end
        if (off) exp_nmi_en = 1'b0;
        else if (on) exp_nmi_en = 1'b1;
        @(posedge clk24);
        #1;
        bus.main_wr = 1'b0;  bus.snd_rd = 1'b0;  bus.snd_wr = 1'b0;  bus.main_rd = 1'b0;
        bus.snd_nmi_on = 1'b0;  bus.snd_nmi_off = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk24);
        #1;
        checks++; if (bus.snd_latch !== 8'h00) begin errors++; $display("FAIL reset_latch: got %h want 00", bus.snd_latch); end
        checks++; if (bus.main_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h want 00", bus.main_din); end
        checks++; if (bus.main_stat !== 4'h0) begin errors++; $display("FAIL reset_main_stat: got %h want 0", bus.main_stat); end
        checks++; if (bus.snd_stat !== 2'b00) begin errors++; $display("FAIL reset_snd_stat: got %b want 00", bus.snd_stat); end
        checks++; if (bus.snd_nmi_n !== 1'b1) begin errors++; $display("FAIL reset_nmi: got %b want 1", bus.snd_nmi_n); end
        rst_n = 1'b1;
    endtask

    task automatic test_nmi();
        cycle(0,0,0,0,1,0,8'h00,8'h00);
        cycle(1,0,0,0,0,0,8'h5A,8'h00);
        checks++; if (bus.snd_latch !== 8'h5A) begin errors++; $display("FAIL nmi_latch: got %h want 5a", bus.snd_latch); end
        checks++; if (bus.main_stat[1] !== 1'b1) begin errors++; $display("FAIL nmi_m2s_full: got %b want 1", bus.main_stat[1]); end
        checks++; if (bus.snd_stat[1] !== 1'b1) begin errors++; $display("FAIL nmi_snd_stat: got %b want 1", bus.snd_stat[1]); end
        checks++; if (bus.snd_nmi_n !== 1'b0) begin errors++; $display("FAIL nmi_assert: got %b want 0", bus.snd_nmi_n); end
        cycle(0,1,0,0,0,0,8'h00,8'h00);
        checks++; if (bus.snd_nmi_n !== 1'b1) begin errors++; $display("FAIL nmi_release: got %b want 1", bus.snd_nmi_n); end
        checks++; if (bus.main_stat[1] !== 1'b0) begin errors++; $display("FAIL nmi_m2s_clear: got %b want 0", bus.main_stat[1]); end
    endtask

    task automatic test_nmi_gate();
        cycle(0,0,0,0,0,1,8'h00,8'h00);
        cycle(1,0,0,0,0,0,8'h11,8'h00);
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus.snd_nmi_n !== 1'b1) begin errors++; $display("FAIL gate_held %0d: got %b want 1", i, bus.snd_nmi_n); end
            cycle(0,0,0,0,0,0,8'h00,8'h00);
        end
        cycle(0,0,0,0,1,0,8'h00,8'h00);
        checks++; if (bus.snd_nmi_n !== 1'b0) begin errors++; $display("FAIL gate_enable: got %b want 0", bus.snd_nmi_n); end
        cycle(0,0,0,0,1,1,8'h00,8'h00);
        checks++; if (bus.snd_nmi_n !== 1'b1) begin errors++; $display("FAIL gate_off_wins: got %b want 1", bus.snd_nmi_n); end
        cycle(0,0,0,0,1,0,8'h00,8'h00);
        cycle(0,1,0,0,0,0,8'h00,8'h00);
        checks++; if (bus.snd_nmi_n !== 1'b1) begin errors++; $display("FAIL gate_release: got %b want 1", bus.snd_nmi_n); end
    endtask

`ifndef JTBUBL_SNDCOMM_FIFO_EN
    task automatic test_overrun();
        cycle(1,0,0,0,0,0,8'h01,8'h00);
        cycle(1,0,0,0,0,0,8'h02,8'h00);
        checks++; if (bus.snd_latch !== 8'h02) begin errors++; $display("FAIL ovr_latch: got %h want 02", bus.snd_latch); end
        checks++; if (bus.main_stat[3] !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", bus.main_stat[3]); end
        cycle(0,1,0,0,0,0,8'h00,8'h00);
        checks++; if (bus.main_stat[3] !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", bus.main_stat[3]); end
        cycle(0,0,0,1,0,0,8'h00,8'h00);
        checks++; if (bus.main_stat[3] !== 1'b0) begin errors++; $display("FAIL ovr_ack: got %b want 0", bus.main_stat[3]); end
    endtask
`else
    task automatic test_fifo();
        cycle(0,0,0,1,1,0,8'h00,8'h00);
        for (int v = 1; v <= 5; v++) cycle(1,0,0,0,0,0,8'(v),8'h00);
        checks++; if (bus.main_stat[3] !== 1'b1) begin errors++; $display("FAIL fifo_drop_ovr: got %b want 1", bus.main_stat[3]); end
        checks++; if (bus.snd_nmi_n !== 1'b0) begin errors++; $display("FAIL fifo_nmi: got %b want 0", bus.snd_nmi_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.snd_latch !== 8'(i + 1)) begin errors++; $display("FAIL fifo_pop %0d: got %h want %h", i, bus.snd_latch, 8'(i + 1)); end
            checks++; if (bus.snd_nmi_n !== 1'b0) begin errors++; $display("FAIL fifo_nmi_hold %0d: got %b want 0", i, bus.snd_nmi_n); end
            cycle(0,1,0,0,0,0,8'h00,8'h00);
        end
        checks++; if (bus.snd_nmi_n !== 1'b1) begin errors++; $display("FAIL fifo_nmi_release: got %b want 1", bus.snd_nmi_n); end
        checks++; if (bus.main_stat[1] !== 1'b0) begin errors++; $display("FAIL fifo_empty: got %b want 0", bus.main_stat[1]); end
        cycle(0,0,0,1,0,0,8'h00,8'h00);
    endtask
`endif

    task automatic test_same_cycle();
        cycle(0,0,0,1,0,0,8'h00,8'h00);
        cycle(1,0,0,0,0,0,8'h20,8'h00);
        cycle(1,1,0,0,0,0,8'h33,8'h00);
        checks++; if (bus.snd_latch !== 8'h33) begin errors++; $display("FAIL same_latch: got %h want 33", bus.snd_latch); end
        checks++; if (bus.main_stat[1] !== 1'b1) begin errors++; $display("FAIL same_full: got %b want 1", bus.main_stat[1]); end
        checks++; if (bus.main_stat[3] !== 1'b0) begin errors++; $display("FAIL same_no_ovr: got %b want 0", bus.main_stat[3]); end
        cycle(0,1,0,0,0,0,8'h00,8'h00);
    endtask

    task automatic test_reply();
        cycle(0,0,1,0,0,0,8'h00,8'hC3);
        checks++; if (bus.main_stat[0] !== 1'b1) begin errors++; $display("FAIL reply_full: got %b want 1", bus.main_stat[0]); end
        checks++; if (bus.snd_stat[0] !== 1'b1) begin errors++; $display("FAIL reply_snd_stat: got %b want 1", bus.snd_stat[0]); end
        cycle(0,0,0,1,0,0,8'h00,8'h00);
        checks++; if (bus.main_din !== 8'hC3) begin errors++; $display("FAIL reply_din: got %h want c3", bus.main_din); end
        checks++; if (bus.main_stat[0] !== 1'b0) begin errors++; $display("FAIL reply_clear: got %b want 0", bus.main_stat[0]); end
        cycle(0,0,1,0,0,0,8'h00,8'h01);
        cycle(0,0,1,0,0,0,8'h00,8'h02);
        checks++; if (bus.main_din !== 8'h02) begin errors++; $display("FAIL reply_overwrite: got %h want 02", bus.main_din); end
        checks++; if (bus.main_stat[2] !== 1'b1) begin errors++; $display("FAIL reply_ovr: got %b want 1", bus.main_stat[2]); end
        cycle(0,0,0,1,0,0,8'h00,8'h00);
        checks++; if (bus.main_stat[2] !== 1'b1) begin errors++; $display("FAIL reply_ovr_sticky: got %b want 1", bus.main_stat[2]); end
        cycle(0,0,0,1,0,0,8'h00,8'h00);
        checks++; if (bus.main_stat[2] !== 1'b0) begin errors++; $display("FAIL reply_ovr_ack: got %b want 0", bus.main_stat[2]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  8'($urandom), 8'($urandom));
            checks++; if (bus.snd_latch !== exp_latch) begin errors++; $display("FAIL rnd_latch @%0d: got %h want %h", n, bus.snd_latch, exp_latch); end
            checks++; if (bus.main_din !== exp_reply) begin errors++; $display("FAIL rnd_din @%0d: got %h want %h", n, bus.main_din, exp_reply); end
            checks++; if (bus.main_stat !== exp_main_stat()) begin errors++; $display("FAIL rnd_main_stat @%0d: got %b want %b", n, bus.main_stat, exp_main_stat()); end
            checks++; if (bus.snd_stat !== {(m2s_q.size() != 0), exp_s_full}) begin errors++; $display("FAIL rnd_snd_stat @%0d: got %b want %b", n, bus.snd_stat, {(m2s_q.size() != 0), exp_s_full}); end
            checks++; if (bus.snd_nmi_n !== exp_nmi_n()) begin errors++; $display("FAIL rnd_nmi @%0d: got %b want %b", n, bus.snd_nmi_n, exp_nmi_n()); end
        end
    endtask

    task automatic test_reset_mid();
        cycle(0,0,0,0,1,0,8'h00,8'h00);
        cycle(1,0,0,0,0,0,8'hAA,8'h00);
        cycle(0,0,1,0,0,0,8'h00,8'h55);
        cycle(1,0,1,0,0,0,8'hBB,8'h66);
        test_reset();
        cycle(1,0,0,0,0,0,8'h77,8'h00);
        checks++; if (bus.snd_latch !== 8'h77) begin errors++; $display("FAIL post_rst_latch: got %h want 77", bus.snd_latch); end
        checks++; if (bus.snd_nmi_n !== ~NMI_EN_RST) begin errors++; $display("FAIL post_rst_nmi_en: got %b want %b", bus.snd_nmi_n, ~NMI_EN_RST); end
        checks++; if (bus.main_stat !== 4'b0010) begin errors++; $display("FAIL post_rst_stat: got %b want 0010", bus.main_stat); end
        cycle(0,1,0,0,0,0,8'h00,8'h00);
    endtask

    initial begin
        bus.main_wr = 1'b0;  bus.main_rd = 1'b0;  bus.snd_rd = 1'b0;  bus.snd_wr = 1'b0;
        bus.snd_nmi_on = 1'b0;  bus.snd_nmi_off = 1'b0;
        bus.main_dout = 8'h00;  bus.snd_dout = 8'h00;
        test_reset();
        test_nmi();
        test_nmi_gate();
`ifndef JTBUBL_SNDCOMM_FIFO_EN
        test_overrun();
`else
        test_fifo();
`endif
        test_same_cycle();
        test_reply();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
